// File: rtl/register_apply_ctrl_if.sv
// Handshake/bus bundle between the config source, register_apply_ctrl and the video logic.
// The master side drives the gated config word and strobes; the slave side returns the applied word and status.
interface register_apply_ctrl_if #(
  parameter int reg_width = 16
);
  logic                 clk_en;
  logic [reg_width-1:0] reg_i;
  logic                 apply_strb;
  logic                 force_apply;
  logic [reg_width-1:0] reg_o;
  logic                 update_o;
  logic                 busy_o;
  logic                 timeout_o;

  modport master (
    output clk_en, reg_i, apply_strb, force_apply,
    input  reg_o, update_o, busy_o, timeout_o
  );

  modport slave (
    input  clk_en, reg_i, apply_strb, force_apply,
    output reg_o, update_o, busy_o, timeout_o
  );
endinterface

// File: rtl/register_apply_ctrl.sv
// Commits a resynchronised config word to the video logic once it has been stable for a while,
// at the next frame-boundary strobe, on force_apply, or after a strobe timeout.
module register_apply_ctrl #(
  parameter int                   reg_width      = 16,
  parameter logic [reg_width-1:0] reg_preset     = '0,
  parameter int                   stable_cycles  = 4,
  parameter int                   timeout_cycles = 2048
) (
  input logic                  clk,
  input logic                  nrst,
  register_apply_ctrl_if.slave bus
);
  localparam int stab_w = $clog2(stable_cycles + 1);
  localparam int to_w   = $clog2(timeout_cycles + 1);
  localparam logic [stab_w-1:0] stab_last = stab_w'(stable_cycles - 1);
  localparam logic [to_w-1:0]   to_last   = to_w'(timeout_cycles - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, ARMED, APPLY} state_t;

  state_t               state_reg;
  logic [reg_width-1:0] pend_reg;
  logic [reg_width-1:0] applied_reg;
  logic [stab_w-1:0]    stab_cnt_reg;
  logic [to_w-1:0]      to_cnt_reg;
  logic                 update_reg;
  logic                 busy_reg;
  logic                 timeout_reg;

  logic pend_changed;
  assign pend_changed = (bus.reg_i != pend_reg);

  // reg_o is loaded on the edge that enters APPLY, so update_o and the new word appear together.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg    <= IDLE;
      pend_reg     <= reg_preset;
      applied_reg  <= reg_preset;
      stab_cnt_reg <= '0;
      to_cnt_reg   <= '0;
      update_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      timeout_reg  <= 1'b0;
    end else if (!bus.clk_en) begin
      update_reg <= 1'b0;
    end else begin
      update_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.reg_i != applied_reg) begin
            pend_reg     <= bus.reg_i;
            stab_cnt_reg <= '0;
            state_reg    <= SETTLE;
            busy_reg     <= 1'b1;
          end
        end
        SETTLE: begin
          if (pend_changed) begin
            pend_reg     <= bus.reg_i;
            stab_cnt_reg <= '0;
          end else if (stab_cnt_reg == stab_last) begin
            // A change that reverted to the applied value needs no commit.
            if (pend_reg == applied_reg) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else begin
              to_cnt_reg <= '0;
              state_reg  <= ARMED;
            end
          end else begin
            stab_cnt_reg <= stab_cnt_reg + 1'b1;
          end
        end
        ARMED: begin
          if (pend_changed) begin
            pend_reg     <= bus.reg_i;
            stab_cnt_reg <= '0;
            state_reg    <= SETTLE;
          end else if (bus.apply_strb || bus.force_apply) begin
            applied_reg <= pend_reg;
            update_reg  <= 1'b1;
            state_reg   <= APPLY;
          end else if (to_cnt_reg == to_last) begin
            applied_reg <= pend_reg;
            update_reg  <= 1'b1;
            timeout_reg <= 1'b1;
            state_reg   <= APPLY;
          end else begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
          end
        end
        APPLY: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.reg_o     = applied_reg;
  assign bus.update_o  = update_reg;
  assign bus.busy_o    = busy_reg;
  assign bus.timeout_o = timeout_reg;
endmodule

// File: tb/tb_register_apply_ctrl.sv
// Directed bench for register_apply_ctrl: a behavioural commit model checked every cycle,
// plus hand-computed expectations for latency, pulse counts and sticky timeout.
module tb_register_apply_ctrl;
  localparam int W       = 16;
  localparam int STABLE  = 4;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic nrst;
  register_apply_ctrl_if #(.reg_width(W)) bus ();

  register_apply_ctrl #(
    .reg_width(W), .reg_preset(16'h0000),
    .stable_cycles(STABLE), .timeout_cycles(TIMEOUT)
  ) dut (
    .clk (clk),
    .nrst(nrst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int  passes = 0;
  int  total = 0;
  int  upd_count = 0;
  int  en_edge = 0;
  int  cyc = 0;
  bit  en_mode = 1'b0;
  bit  chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // clk_en: always on, or one enabled cycle in three
  always @(posedge clk) begin
    #1;
    cyc++;
    bus.clk_en = en_mode ? (cyc % 3 == 0) : 1'b1;
  end

  always @(posedge clk) if (nrst === 1'b1 && bus.clk_en === 1'b1) en_edge++;
  always @(negedge clk) if (bus.update_o === 1'b1) upd_count++;

  // Behavioural model: a candidate word, how long it has held, and how long it has waited for a strobe.
  logic [W-1:0] m_out = '0;
  logic [W-1:0] m_cand = '0;
  bit m_busy = 0, m_applying = 0, m_upd = 0, m_to = 0;
  int m_run = 0;
  int m_age = -1;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_out = '0; m_cand = '0; m_busy = 0; m_applying = 0;
      m_upd = 0; m_to = 0; m_run = 0; m_age = -1;
    end else begin
      m_upd = 0;
      if (bus.clk_en === 1'b1) begin
        if (m_applying) begin
          m_applying = 0;
          m_busy = 0;
        end else if (!m_busy) begin
          if (bus.reg_i != m_out) begin
            m_cand = bus.reg_i; m_run = 0; m_age = -1; m_busy = 1;
          end
        end else if (bus.reg_i != m_cand) begin
          m_cand = bus.reg_i; m_run = 0; m_age = -1;
        end else if (m_age < 0) begin
          if (m_run == STABLE - 1) begin
            if (m_cand == m_out) m_busy = 0;
            else m_age = 0;
          end else m_run++;
        end else if (bus.apply_strb || bus.force_apply || m_age == TIMEOUT - 1) begin
          if (!(bus.apply_strb || bus.force_apply)) m_to = 1;
          m_out = m_cand; m_upd = 1; m_applying = 1;
        end else m_age++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_reg_o", 32'(bus.reg_o), 32'(m_out));
      check("model_update_o", 32'(bus.update_o), 32'(m_upd));
      check("model_busy_o", 32'(bus.busy_o), 32'(m_busy));
      check("model_timeout_o", 32'(bus.timeout_o), 32'(m_to));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int u0, c0, n;
    nrst = 1'b0;
    bus.reg_i = '0;
    bus.apply_strb = 1'b0;
    bus.force_apply = 1'b0;
    step(3);
    chk_on = 1'b1;
    nrst = 1'b1;

    // 1: idle with preset input
    step(100);
    check("t1_reg_o", 32'(bus.reg_o), 32'h0);
    check("t1_updates", 32'(upd_count), 32'd0);
    check("t1_busy", 32'(bus.busy_o), 32'd0);

    // 2: minimum latency with strobe held high
    u0 = upd_count;
    bus.apply_strb = 1'b1;
    bus.reg_i = 16'h00A5;
    c0 = en_edge;
    step(5);
    check("t2_no_early_pulse", 32'(bus.update_o), 32'd0);
    check("t2_old_reg_o", 32'(bus.reg_o), 32'h0);
    step(1);
    check("t2_latency", 32'(en_edge - c0), 32'd6);
    check("t2_pulse", 32'(bus.update_o), 32'd1);
    check("t2_reg_o", 32'(bus.reg_o), 32'h00A5);
    step(3);
    check("t2_single_pulse", 32'(upd_count - u0), 32'd1);
    check("t2_busy_clear", 32'(bus.busy_o), 32'd0);
    bus.apply_strb = 1'b0;

    // 3: toggling input never settles
    u0 = upd_count;
    for (int k = 0; k < 25; k++) begin
      bus.reg_i = (k % 2 == 1) ? 16'h0002 : 16'h0001;
      step(2);
      if (k == 12) check("t3_busy_toggling", 32'(bus.busy_o), 32'd1);
    end
    check("t3_no_commit", 32'(upd_count - u0), 32'd0);
    bus.reg_i = 16'h0002;
    step(8);
    check("t3_armed_busy", 32'(bus.busy_o), 32'd1);
    check("t3_still_no_commit", 32'(upd_count - u0), 32'd0);
    bus.apply_strb = 1'b1;
    step(1);
    bus.apply_strb = 1'b0;
    check("t3_pulse", 32'(bus.update_o), 32'd1);
    check("t3_reg_o", 32'(bus.reg_o), 32'h0002);
    step(2);
    check("t3_single_commit", 32'(upd_count - u0), 32'd1);

    // 4: change reverts inside the settle window
    u0 = upd_count;
    bus.reg_i = 16'h0003;
    step(2);
    bus.reg_i = 16'h0002;
    step(10);
    check("t4_busy", 32'(bus.busy_o), 32'd0);
    check("t4_reg_o", 32'(bus.reg_o), 32'h0002);
    check("t4_no_pulse", 32'(upd_count - u0), 32'd0);

    // 5a: strobe on the 15th armed cycle
    bus.reg_i = 16'h0010;
    step(5 + 14);
    bus.apply_strb = 1'b1;
    step(1);
    bus.apply_strb = 1'b0;
    check("t5a_pulse", 32'(bus.update_o), 32'd1);
    check("t5a_reg_o", 32'(bus.reg_o), 32'h0010);
    check("t5a_timeout", 32'(bus.timeout_o), 32'd0);
    step(2);

    // 5b: strobe in the same cycle as the timeout wins
    bus.reg_i = 16'h0011;
    step(5 + 15);
    check("t5b_no_early", 32'(bus.update_o), 32'd0);
    bus.apply_strb = 1'b1;
    step(1);
    bus.apply_strb = 1'b0;
    check("t5b_pulse", 32'(bus.update_o), 32'd1);
    check("t5b_strobe_beats_timeout", 32'(bus.timeout_o), 32'd0);
    step(2);

    // 5c: forced commit by timeout
    bus.reg_i = 16'h0012;
    step(5 + 15);
    check("t5c_no_early", 32'(bus.update_o), 32'd0);
    check("t5c_timeout_low", 32'(bus.timeout_o), 32'd0);
    step(1);
    check("t5c_pulse", 32'(bus.update_o), 32'd1);
    check("t5c_reg_o", 32'(bus.reg_o), 32'h0012);
    check("t5c_timeout_set", 32'(bus.timeout_o), 32'd1);
    step(2);

    // 5d: force_apply commits and timeout stays sticky
    bus.reg_i = 16'h0055;
    bus.force_apply = 1'b1;
    c0 = en_edge;
    step(6);
    bus.force_apply = 1'b0;
    check("t5d_latency", 32'(en_edge - c0), 32'd6);
    check("t5d_reg_o", 32'(bus.reg_o), 32'h0055);
    check("t5d_timeout_sticky", 32'(bus.timeout_o), 32'd1);
    step(2);

    // 5e: input change in ARMED beats the strobe
    bus.reg_i = 16'h0066;
    step(5);
    bus.reg_i = 16'h0067;
    bus.apply_strb = 1'b1;
    step(1);
    bus.apply_strb = 1'b0;
    check("t5e_change_beats_strobe", 32'(bus.update_o), 32'd0);
    step(4);
    bus.apply_strb = 1'b1;
    step(1);
    bus.apply_strb = 1'b0;
    check("t5e_reg_o", 32'(bus.reg_o), 32'h0067);
    step(2);

    // 6: 1/3 clock enable, then reset while ARMED
    en_mode = 1'b1;
    bus.apply_strb = 1'b1;
    bus.reg_i = 16'h0040;
    c0 = en_edge;
    n = 0;
    while (bus.update_o !== 1'b1 && n < 200) begin
      step(1);
      n++;
    end
    check("t6_commit_seen", 32'(n < 200), 32'd1);
    check("t6_enabled_latency", 32'(en_edge - c0), 32'd6);
    check("t6_gated_clocks", 32'(n >= 16), 32'd1);
    check("t6_reg_o", 32'(bus.reg_o), 32'h0040);
    bus.apply_strb = 1'b0;
    step(3);
    bus.reg_i = 16'h0080;
    step(30);
    check("t6_armed_busy", 32'(bus.busy_o), 32'd1);
    check("t6_pending_not_applied", 32'(bus.reg_o), 32'h0040);
    #2;
    nrst = 1'b0;
    #1;
    check("t6_rst_reg_o", 32'(bus.reg_o), 32'h0);
    check("t6_rst_busy", 32'(bus.busy_o), 32'd0);
    check("t6_rst_update", 32'(bus.update_o), 32'd0);
    check("t6_rst_timeout", 32'(bus.timeout_o), 32'd0);
    bus.reg_i = 16'h0000;
    u0 = upd_count;
    step(2);
    nrst = 1'b1;
    en_mode = 1'b0;
    step(20);
    check("t6_no_pulse_after_rst", 32'(upd_count - u0), 32'd0);
    check("t6_reg_o_preset", 32'(bus.reg_o), 32'h0);

    step(2);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
